// File: rtl/game_pkg.sv
// Shared state encoding, default timing constants and ghost indices for the
// game sequencer and its helpers.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DEATH = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int unsigned DEF_LIVES        = 3;
  localparam int unsigned DEF_READY_FRAMES = 120;
  localparam int unsigned DEF_DEATH_FRAMES = 90;
  localparam int unsigned DEF_BLUE_FRAMES  = 360;
  localparam int unsigned DEF_WARN_FRAMES  = 120;
  localparam int unsigned DEF_GHOST_DIV    = 2;

  localparam int unsigned RED   = 0;
  localparam int unsigned GREEN = 1;
  localparam int unsigned PINK  = 2;

endpackage

// File: rtl/frame_sync.sv
// Brings the VGA vsync level into the Clk domain and emits one registered
// pulse per frame on each genuine rising edge.
module frame_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_vs_i,
  output logic frame_tick_o
);

  logic       sync1_q, sync2_q, prev_q, armed_q, tick_q;
  logic [1:0] fill_q;

  // NOTE: every flop here uses <= so all stages sample the pre-edge values;
  // blocking assignments would collapse the synchronizer into a single flop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_vs_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      // Only a low level actually sampled after reset arms the edge detector,
      // so releasing reset while vsync is high cannot fake a rising edge.
      if (fill_q[1] && !sync2_q) armed_q <= 1'b1;
      tick_q  <= sync2_q & ~prev_q & armed_q;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM (idle/ready/play/death/over), power-pellet blue timer and
// round-robin ghost step scheduler, all paced by the frame tick.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES        = DEF_LIVES,
  parameter int unsigned READY_FRAMES = DEF_READY_FRAMES,
  parameter int unsigned DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int unsigned BLUE_FRAMES  = DEF_BLUE_FRAMES,
  parameter int unsigned WARN_FRAMES  = DEF_WARN_FRAMES,
  parameter int unsigned GHOST_DIV    = DEF_GHOST_DIV
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_vs,
  input  logic       start,
  input  logic       collide,
  input  logic       pellet,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       round_reset,
  output logic       frame_tick,
  output logic [2:0] ghost_step,
  output logic       blue,
  output logic       blue_warn,
  output logic       over
);

  localparam int unsigned FRAME_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int unsigned FCW = $clog2(FRAME_MAX + 1);
  localparam int unsigned BCW = $clog2(BLUE_FRAMES + 1);
  localparam int unsigned DCW = $clog2(2 * GHOST_DIV + 1);

  state_e         state_q, state_d;
  logic [1:0]     lives_q, lives_d;
  logic           rr_q, rr_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BCW-1:0] blue_cnt_q, blue_cnt_d;
  logic           blue_q, warn_q, over_q;
  logic [DCW-1:0] div_q, div_d, div_inc, div_limit;
  logic [2:0]     ghost_q, ghost_d;
  logic           seq_start;
  logic           tick;

  frame_sync u_frame_sync (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_vs_i   (frame_vs),
    .frame_tick_o (tick)
  );

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    rr_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_READY;
          lives_d = 2'(LIVES);
          rr_d    = 1'b1;
        end
      end
      ST_READY: begin
        if (tick && frame_cnt_q == FCW'(READY_FRAMES - 1)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (collide && !blue_q) state_d = ST_DEATH;
      end
      ST_DEATH: begin
        if (tick && frame_cnt_q == FCW'(DEATH_FRAMES - 1)) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            rr_d    = 1'b1;
            state_d = ST_READY;
          end else begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (tick && (state_q == ST_READY || state_q == ST_DEATH)) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end
  end

  // Leaving PLAY (including a same-cycle collide+pellet death) clears the timer.
  always_comb begin
    blue_cnt_d = '0;
    if (state_q == ST_PLAY && state_d == ST_PLAY) begin
      if (pellet)                         blue_cnt_d = BCW'(BLUE_FRAMES);
      else if (tick && blue_cnt_q != '0)  blue_cnt_d = blue_cnt_q - BCW'(1);
      else                                blue_cnt_d = blue_cnt_q;
    end
  end

  assign div_inc   = div_q + DCW'(1);
  assign div_limit = blue_q ? DCW'(2 * GHOST_DIV) : DCW'(GHOST_DIV);

  // The strobe shifts on regardless of state so a started sequence finishes.
  always_comb begin
    div_d     = '0;
    seq_start = 1'b0;
    if (state_q == ST_PLAY) begin
      div_d = div_q;
      if (tick) begin
        if (div_inc >= div_limit) begin
          div_d     = '0;
          seq_start = 1'b1;
        end else begin
          div_d = div_inc;
        end
      end
    end
    ghost_d = '0;
    if (seq_start) begin
      ghost_d[RED] = 1'b1;
    end else begin
      ghost_d[GREEN] = ghost_q[RED];
      ghost_d[PINK]  = ghost_q[GREEN];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      lives_q     <= 2'd0;
      rr_q        <= 1'b0;
      frame_cnt_q <= '0;
      blue_cnt_q  <= '0;
      blue_q      <= 1'b0;
      warn_q      <= 1'b0;
      over_q      <= 1'b0;
      div_q       <= '0;
      ghost_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      rr_q        <= rr_d;
      frame_cnt_q <= frame_cnt_d;
      blue_cnt_q  <= blue_cnt_d;
      blue_q      <= (blue_cnt_d != '0);
      warn_q      <= (blue_cnt_d != '0) && (blue_cnt_d <= BCW'(WARN_FRAMES));
      over_q      <= (state_d == ST_OVER);
      div_q       <= div_d;
      ghost_q     <= ghost_d;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign round_reset = rr_q;
  assign frame_tick  = tick;
  assign ghost_step  = ghost_q;
  assign blue        = blue_q;
  assign blue_warn   = warn_q;
  assign over        = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scenarios for game_sequencer, checked every cycle against a
// frame-level behavioural model plus hand-computed milestone values.
module tb_game_sequencer;

  localparam int L_INIT = 3;
  localparam int RF     = 120;
  localparam int DF     = 90;
  localparam int BF     = 360;
  localparam int WF     = 120;
  localparam int GD     = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_vs = 1'b0;
  logic       start = 1'b0;
  logic       collide = 1'b0;
  logic       pellet = 1'b0;
  logic [2:0] state;
  logic [1:0] lives;
  logic       round_reset, frame_tick;
  logic [2:0] ghost_step;
  logic       blue, blue_warn, over;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  game_sequencer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_vs    (frame_vs),
    .start       (start),
    .collide     (collide),
    .pellet      (pellet),
    .state       (state),
    .lives       (lives),
    .round_reset (round_reset),
    .frame_tick  (frame_tick),
    .ghost_step  (ghost_step),
    .blue        (blue),
    .blue_warn   (blue_warn),
    .over        (over)
  );

  task automatic check(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: frames remaining per phase, blue frames remaining,
  // a queue of pending ghost strobes, and the vsync sample history.
  int m_state, m_lives, m_left, m_blue, m_div, m_k, m_rr, m_tick, m_over, m_ghost;
  int m_s1, m_s2, m_s3;
  int m_gq[$];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_state = 0; m_lives = 0; m_left = 0; m_blue = 0; m_div = 0; m_k = 0;
      m_rr = 0; m_tick = 0; m_over = 0; m_ghost = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      m_gq.delete();
    end else begin
      int ns, nl, nleft, nrr, nblue, ndiv, lim;
      bit bl, restart;
      m_k++;
      bl = (m_blue > 0);
      ns = m_state; nl = m_lives; nleft = m_left; nrr = 0; restart = 0;
      case (m_state)
        0, 4: if (start) begin ns = 1; nl = L_INIT; nrr = 1; nleft = RF; end
        1: if (m_tick != 0) begin nleft--; if (nleft == 0) ns = 2; end
        2: if (collide && !bl) begin ns = 3; nleft = DF; end
        3: if (m_tick != 0) begin
             nleft--;
             if (nleft == 0) begin
               if (m_lives > 1) begin nl = m_lives - 1; nrr = 1; ns = 1; nleft = RF; end
               else begin nl = 0; ns = 4; end
             end
           end
        default: ns = 0;
      endcase
      if (m_state == 2 && ns == 2) begin
        if (pellet) nblue = BF;
        else if (m_tick != 0 && m_blue > 0) nblue = m_blue - 1;
        else nblue = m_blue;
      end else begin
        nblue = 0;
      end
      ndiv = 0;
      if (m_state == 2) begin
        ndiv = m_div;
        if (m_tick != 0) begin
          ndiv++;
          lim = bl ? 2 * GD : GD;
          if (ndiv >= lim) begin ndiv = 0; restart = 1; end
        end
      end
      if (restart) begin
        m_gq.delete(); m_gq.push_back(1); m_gq.push_back(2); m_gq.push_back(4);
      end
      m_ghost = (m_gq.size() > 0) ? m_gq.pop_front() : 0;
      // A tick needs a rising edge between two vsync samples taken after reset.
      m_tick = (m_k >= 4 && m_s2 == 1 && m_s3 == 0) ? 1 : 0;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = int'(frame_vs);
      m_state = ns; m_lives = nl; m_left = nleft; m_rr = nrr;
      m_blue = nblue; m_div = ndiv; m_over = (ns == 4) ? 1 : 0;
    end
  end

  always @(negedge Clk) begin
    check("m_state", state, m_state);
    check("m_lives", lives, m_lives);
    check("m_round_reset", round_reset, m_rr);
    check("m_frame_tick", frame_tick, m_tick);
    check("m_ghost_step", ghost_step, m_ghost);
    check("m_blue", blue, (m_blue > 0) ? 1 : 0);
    check("m_blue_warn", blue_warn, (m_blue > 0 && m_blue <= WF) ? 1 : 0);
    check("m_over", over, m_over);
  end

  int rr_cnt = 0, tick_cnt = 0, seq_cnt = 0, seq_after_tick = 0;
  bit prev_tick = 0;
  always @(negedge Clk) begin
    if (round_reset) rr_cnt++;
    if (frame_tick) tick_cnt++;
    if (ghost_step == 3'b001) begin
      seq_cnt++;
      if (prev_tick) seq_after_tick++;
    end
    prev_tick = frame_tick;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_vs = 1'b1; cyc(4);
      frame_vs = 1'b0; cyc(4);
    end
  endtask

  task automatic pulse_in(input int which);
    if (which == 0) start = 1'b1;
    if (which == 1) collide = 1'b1;
    if (which == 2) pellet = 1'b1;
    cyc(1);
    start = 1'b0; collide = 1'b0; pellet = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_lives"}, lives, 0);
    check({tag, "_round_reset"}, round_reset, 0);
    check({tag, "_frame_tick"}, frame_tick, 0);
    check({tag, "_ghost_step"}, ghost_step, 0);
    check({tag, "_blue"}, blue, 0);
    check({tag, "_blue_warn"}, blue_warn, 0);
    check({tag, "_over"}, over, 0);
  endtask

  initial begin
    int r0, t0, s0, a0, n, warn_at;
    bit found;

    cyc(3);
    check_all_zero("reset");
    Reset_n = 1'b1;
    cyc(5);

    // Start from IDLE, then READY for exactly RF frames.
    r0 = rr_cnt; t0 = tick_cnt;
    pulse_in(0);
    check("start_state", state, 1);
    check("start_lives", lives, 3);
    check("start_round_reset", round_reset, 1);
    cyc(2);
    check("start_rr_pulses", rr_cnt - r0, 1);
    frames(RF - 1);
    check("ready_before_last", state, 1);
    frames(1);
    check("ready_to_play", state, 2);
    check("ready_ticks", tick_cnt - t0, RF);

    // Normal ghost pacing: one sequence every GHOST_DIV ticks.
    s0 = seq_cnt; a0 = seq_after_tick;
    frames(4);
    check("ghost_seq_normal", seq_cnt - s0, 2);
    check("ghost_seq_after_tick", seq_after_tick - a0, 2);
    check("ghost_blue_off", blue, 0);

    // Power pellet: blue for BF ticks, warning for the last WF, half ghost rate.
    pulse_in(2);
    check("pellet_blue", blue, 1);
    check("pellet_warn", blue_warn, 0);
    s0 = seq_cnt;
    frames(8);
    check("ghost_seq_blue8", seq_cnt - s0, 2);
    n = 8; warn_at = 0;
    while (blue && n < 400) begin
      frames(1);
      n++;
      if (blue_warn && warn_at == 0) warn_at = n;
    end
    check("blue_frames", n, BF);
    check("warn_first_frame", warn_at, BF - WF);
    check("ghost_seq_blue_total", seq_cnt - s0, BF / (2 * GD));
    check("blue_end_state", state, 2);

    // Collide and pellet together while not blue: death wins.
    collide = 1'b1; pellet = 1'b1;
    cyc(1);
    collide = 1'b0; pellet = 1'b0;
    check("death_state", state, 3);
    check("death_blue", blue, 0);
    r0 = rr_cnt;
    frames(DF - 1);
    check("death_before_last", state, 3);
    frames(1);
    check("death1_state", state, 1);
    check("death1_lives", lives, 2);
    check("death1_rr", rr_cnt - r0, 1);

    // Two more deaths end the game.
    frames(RF);
    check("play2_state", state, 2);
    pulse_in(1);
    check("death2_enter", state, 3);
    frames(DF);
    check("death2_state", state, 1);
    check("death2_lives", lives, 1);
    frames(RF);
    pulse_in(1);
    r0 = rr_cnt;
    frames(DF);
    check("over_state", state, 4);
    check("over_flag", over, 1);
    check("over_lives", lives, 0);
    check("over_no_rr", rr_cnt - r0, 0);
    pulse_in(0);
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    cyc(1);
    check("restart_rr", rr_cnt - r0, 1);

    // Reset in the middle of blue and of a ghost sequence.
    frames(RF);
    check("play3_state", state, 2);
    pulse_in(2);
    frames(3);
    frame_vs = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (ghost_step == 3'b001) found = 1;
    end
    check("midseq_found", found, 1);
    check("midseq_blue", blue, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    cyc(2);
    Reset_n = 1'b1;
    t0 = tick_cnt;
    cyc(12);
    check("no_spurious_tick", tick_cnt - t0, 0);
    frame_vs = 1'b0; cyc(4);
    frame_vs = 1'b1; cyc(4);
    check("tick_after_edge", tick_cnt - t0, 1);
    frame_vs = 1'b0; cyc(4);
    check("post_reset_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
